int_controller: RTL and testbench
=================================

Name: int_controller

Overview:
- Programmable interrupt controller that drives the CPU's 16-bit `interrupts` input. Today that input is tied to 0.
- Collects up to 16 device request lines, e.g. PS/2 ready, UART rx, VGA vsync.
- Latches, masks and prioritises requests, and presents one request at a time.
- Tracks in-service nesting and is programmed by the CPU through a small memory-mapped register window. Read port has the same 1-cycle latency as `mem`.

Parameters:
- NUM_SRC, 16, number of request inputs; must be 16 to match the CPU `interrupts` width.
- EDGE_MASK, 16'hFFFF, per source: 1 = rising-edge triggered, 0 = level triggered.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- irq_src  in  16  device request lines, synchronous to clk
- reg_wen  in  1  register write strobe
- reg_waddr  in  2  register write index
- reg_wdata  in  16  register write data
- reg_raddr  in  2  register read index
- reg_rdata  out  16  register read data, registered
- interrupts  out  16  one-hot presented request to the CPU; 0 = none
- int_ack  in  1  CPU pulse: presented request has been taken

Behaviour:
- Reset (synchronous, clk edge with rst=1): clears `pending`, `mask`, `in_service`, `prev_src`, `interrupts` and `reg_rdata` to 0. rst overrides every other input in that cycle.
- Register map:
  - 0 PENDING: read; write-1-to-clear.
  - 1 MASK: read/write; 1 = enabled.
  - 2 IN_SERVICE: read-only; writes ignored.
  - 3 EOI: write any value clears the lowest-index set bit of `in_service`; reads return 0.
- Source detection: `prev_src <= irq_src` every cycle.
  - Edge source i: `set[i] = irq_src[i] & ~prev_src[i]`.
  - Level source i: `set[i] = irq_src[i]`.
- Pending update per bit: `pending_next = (pending & ~clr) | set`. Set wins over a same-cycle W1C or ack clear.
- Priority: bit 0 highest, bit 15 lowest.
  - `cand` = lowest-index bit of `pending & mask`.
  - `cand` is eligible only if its index is strictly lower than the lowest set bit of `in_service`, or `in_service == 0`.
- Output: `interrupts <=` one-hot(cand) if eligible, else 0.
  - Registered, so a new edge appears on `interrupts` 2 cycles after the irq_src rise: cycle 1 sets pending, cycle 2 updates the output.
  - Output is recomputed every cycle. A higher-priority arrival replaces the presented bit. Masking or clearing the presented bit drops it the next cycle.
- Ack: at a clk edge with `int_ack=1` and `interrupts != 0`, the presented bit k is cleared from `pending` (unless re-set the same cycle) and set in `in_service`.
  - `interrupts` goes to 0 the following cycle, because k is no longer pending.
  - `int_ack` with `interrupts == 0` is ignored.
  - The CPU holds `int_ack` for exactly 1 cycle.
- Nesting: `in_service` may hold several bits. Only strictly higher priority than the current lowest in-service bit preempts.
- EOI with `in_service == 0`: no effect. EOI and ack in the same cycle: EOI clears the old lowest bit first, then the ack bit is set.
- Read: `reg_rdata <=` register[reg_raddr], 1-cycle latency. It returns the value before any same-cycle write. Valid every cycle; there is no read strobe.
- Level sources still asserted after ack re-pend the next cycle. The handler must silence the device before EOI.
- Reset mid-sequence (presented or in service): everything is cleared. A level source still high re-pends 1 cycle after rst deasserts.
- Synthesizable. Expected size is about 150 lines.

Test Plan:
- Reset and mask:
  - Reset, then MASK=0x0000, pulse irq_src[3] for 1 cycle. Expect PENDING read = 0x0008 and `interrupts` = 0.
  - Write MASK=0x0008. Expect `interrupts` = 0x0008 in the cycle after the write lands.
- Priority and preemption:
  - MASK=0xFFFF; rise src[5] and src[2] in the same cycle. Expect `interrupts` = 0x0004.
  - Ack: expect IN_SERVICE = 0x0004, then `interrupts` = 0x0000, because 5 is lower priority than 2.
  - EOI: expect `interrupts` = 0x0020.
- Nesting:
  - With src[4] in service, rise src[1]. Expect `interrupts` = 0x0002.
  - Ack: expect IN_SERVICE = 0x0012.
  - One EOI: expect IN_SERVICE = 0x0010.
- Simultaneous events:
  - Edge on src[7] in the same cycle as a W1C PENDING=0x0080. Expect PENDING remains 0x0080.
  - `int_ack` while `interrupts` = 0: expect no state change.
- Level source:
  - EDGE_MASK=16'hFFFE, src[0] held high, ack. Expect PENDING bit0 = 1 again the next cycle, and `interrupts` = 0 while bit0 is in service.
  - Drop src[0], then W1C PENDING=0x0001, then EOI. Expect `interrupts` stays 0.
- Reset mid-operation:
  - rst=1 for 1 cycle with IN_SERVICE = 0x0001 and PENDING = 0x8000. Expect all registers and `interrupts` read 0 on the next cycle.

Source files
------------

// File: rtl/int_controller.sv
// Programmable interrupt controller: latches edge/level requests, masks and
// prioritises them, tracks in-service nesting and presents one one-hot request.
module int_controller #(
  parameter int unsigned          NUM_SRC   = 16,
  parameter logic [NUM_SRC-1:0]   EDGE_MASK = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               reg_wen,
  input  logic [1:0]         reg_waddr,
  input  logic [NUM_SRC-1:0] reg_wdata,
  input  logic [1:0]         reg_raddr,
  output logic [NUM_SRC-1:0] reg_rdata,
  output logic [NUM_SRC-1:0] interrupts,
  input  logic               int_ack
);

  typedef enum logic [1:0] {
    REG_PENDING    = 2'd0,
    REG_MASK       = 2'd1,
    REG_IN_SERVICE = 2'd2,
    REG_EOI        = 2'd3
  } reg_idx_e;

  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] in_service_q, in_service_d;
  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] interrupts_q, interrupts_d;
  logic [NUM_SRC-1:0] rdata_q, rdata_d;

  logic [NUM_SRC-1:0] set_v, clr_v, cand, is_low;
  logic               ack_take;
  reg_idx_e           wsel, rsel;

  // Isolate the lowest set bit; with bit 0 highest priority this is the winner.
  function automatic logic [NUM_SRC-1:0] lowest_bit(input logic [NUM_SRC-1:0] x);
    return x & (~x + {{(NUM_SRC-1){1'b0}}, 1'b1});
  endfunction

  always_comb begin
    wsel     = reg_idx_e'(reg_waddr);
    rsel     = reg_idx_e'(reg_raddr);
    ack_take = int_ack && (interrupts_q != '0);

    set_v = (irq_src & ~prev_q & EDGE_MASK) | (irq_src & ~EDGE_MASK);
    clr_v = '0;
    if (reg_wen && wsel == REG_PENDING) clr_v = clr_v | reg_wdata;
    if (ack_take)                       clr_v = clr_v | interrupts_q;
    pending_d = (pending_q & ~clr_v) | set_v;

    mask_d = mask_q;
    if (reg_wen && wsel == REG_MASK) mask_d = reg_wdata;

    is_low       = lowest_bit(in_service_q);
    in_service_d = in_service_q;
    if (reg_wen && wsel == REG_EOI) in_service_d = in_service_d & ~is_low;
    if (ack_take)                   in_service_d = in_service_d | interrupts_q;

    // One-hot values compare like indices: a smaller value is a lower index.
    cand = lowest_bit(pending_q & mask_q);
    interrupts_d = '0;
    if (cand != '0 && (is_low == '0 || cand < is_low)) interrupts_d = cand;

    rdata_d = '0;
    case (rsel)
      REG_PENDING:    rdata_d = pending_q;
      REG_MASK:       rdata_d = mask_q;
      REG_IN_SERVICE: rdata_d = in_service_q;
      default:        rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= '0;
      mask_q       <= '0;
      in_service_q <= '0;
      prev_q       <= '0;
      interrupts_q <= '0;
      rdata_q      <= '0;
    end else begin
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      in_service_q <= in_service_d;
      prev_q       <= irq_src;
      interrupts_q <= interrupts_d;
      rdata_q      <= rdata_d;
    end
  end

  assign interrupts = interrupts_q;
  assign reg_rdata  = rdata_q;

endmodule

// File: tb/tb_int_controller.sv
// Scoreboard bench for int_controller: directed scenarios then random traffic,
// checked against an index-based reference model of the controller.
module tb_int_controller;

  localparam logic [15:0] EM = 16'hFFFE;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] irq_src;
  logic        reg_wen;
  logic [1:0]  reg_waddr;
  logic [15:0] reg_wdata;
  logic [1:0]  reg_raddr;
  logic [15:0] reg_rdata;
  logic [15:0] interrupts;
  logic        int_ack;

  int_controller #(.NUM_SRC(16), .EDGE_MASK(EM)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .reg_wen(reg_wen),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .reg_raddr(reg_raddr),
    .reg_rdata(reg_rdata), .interrupts(interrupts), .int_ack(int_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [15:0] ints;
    logic [15:0] rd;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int step_no = 0;

  bit          m_pend[16];
  bit          m_mask[16];
  bit          m_ins[16];
  bit          m_prev[16];
  int          m_pres;   // index presented to the CPU, -1 when none

  function automatic logic [15:0] pack(input bit a[16]);
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = a[i];
    return v;
  endfunction

  task automatic step(input logic r, input logic [15:0] src, input logic wen,
                      input logic [1:0] wa, input logic [15:0] wd,
                      input logic [1:0] ra, input logic ack);
    exp_t e;
    bit np[16];
    bit nins[16];
    int lis, c;
    logic [15:0] rd;
    rst = r; irq_src = src; reg_wen = wen; reg_waddr = wa;
    reg_wdata = wd; reg_raddr = ra; int_ack = ack;
    if (r) begin
      for (int i = 0; i < 16; i++) begin
        m_pend[i] = 0; m_mask[i] = 0; m_ins[i] = 0; m_prev[i] = 0;
      end
      m_pres = -1;
      rd = '0;
    end else begin
      lis = 16;
      for (int i = 15; i >= 0; i--) if (m_ins[i]) lis = i;
      c = -1;
      for (int i = 15; i >= 0; i--) if (m_pend[i] && m_mask[i]) c = i;
      case (ra)
        2'd0:    rd = pack(m_pend);
        2'd1:    rd = pack(m_mask);
        2'd2:    rd = pack(m_ins);
        default: rd = '0;
      endcase
      for (int i = 0; i < 16; i++) begin
        bit s, k;
        s = EM[i] ? (src[i] && !m_prev[i]) : src[i];
        k = (wen && wa == 2'd0 && wd[i]) || (ack && i == m_pres);
        np[i] = s || (m_pend[i] && !k);
        nins[i] = m_ins[i];
      end
      if (wen && wa == 2'd3 && lis < 16) nins[lis] = 0;
      if (ack && m_pres >= 0) nins[m_pres] = 1;
      for (int i = 0; i < 16; i++) begin
        m_pend[i] = np[i];
        m_ins[i]  = nins[i];
        m_prev[i] = src[i];
        if (wen && wa == 2'd1) m_mask[i] = wd[i];
      end
      m_pres = (c >= 0 && c < lis) ? c : -1;
    end
    e.id   = step_no;
    e.ints = (m_pres >= 0) ? (16'd1 << m_pres) : 16'd0;
    e.rd   = rd;
    sb.push_back(e);
    step_no++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [1:0] ra);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 2'd0, 16'h0, ra, 1'b0);
  endtask

  task automatic wr(input logic [1:0] wa, input logic [15:0] wd, input logic [1:0] ra);
    step(1'b0, 16'h0, 1'b1, wa, wd, ra, 1'b0);
  endtask

  task automatic ack1(input logic [1:0] ra);
    step(1'b0, 16'h0, 1'b0, 2'd0, 16'h0, ra, 1'b1);
  endtask

  task automatic reset1;
    step(1'b1, 16'h0, 1'b0, 2'd0, 16'h0, 2'd0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks += 2;
      if (interrupts !== e.ints) begin
        errors++;
        $display("FAIL interrupts step %0d: got %h expected %h", e.id, interrupts, e.ints);
      end
      if (reg_rdata !== e.rd) begin
        errors++;
        $display("FAIL reg_rdata step %0d: got %h expected %h", e.id, reg_rdata, e.rd);
      end
    end
  end

  initial begin
    bit last_ack;
    logic [15:0] src;
    m_pres = -1;

    // Reset, then masked pending and unmasking.
    reset1();
    wr(2'd1, 16'h0000, 2'd0);
    step(1'b0, 16'h0008, 1'b0, 2'd0, 16'h0, 2'd0, 1'b0);
    idle(3, 2'd0);
    wr(2'd1, 16'h0008, 2'd1);
    idle(3, 2'd0);
    ack1(2'd2);
    idle(2, 2'd2);
    wr(2'd3, 16'h1234, 2'd2);
    idle(2, 2'd3);

    // Priority and preemption.
    reset1();
    wr(2'd1, 16'hFFFF, 2'd1);
    step(1'b0, 16'h0024, 1'b0, 2'd0, 16'h0, 2'd0, 1'b0);
    idle(3, 2'd0);
    ack1(2'd2);
    idle(3, 2'd2);
    wr(2'd3, 16'h0, 2'd2);
    idle(3, 2'd0);
    ack1(2'd2);
    wr(2'd3, 16'h0, 2'd2);
    idle(2, 2'd2);

    // Nesting.
    reset1();
    wr(2'd1, 16'hFFFF, 2'd1);
    step(1'b0, 16'h0010, 1'b0, 2'd0, 16'h0, 2'd0, 1'b0);
    idle(2, 2'd0);
    ack1(2'd2);
    idle(1, 2'd2);
    step(1'b0, 16'h0002, 1'b0, 2'd0, 16'h0, 2'd2, 1'b0);
    idle(2, 2'd0);
    ack1(2'd2);
    idle(2, 2'd2);
    wr(2'd3, 16'h0, 2'd2);
    idle(2, 2'd2);
    wr(2'd3, 16'h0, 2'd2);
    wr(2'd3, 16'h0, 2'd2);
    idle(2, 2'd2);

    // Set beats a same-cycle W1C; ack with nothing presented.
    reset1();
    step(1'b0, 16'h0080, 1'b1, 2'd0, 16'h0080, 2'd0, 1'b0);
    idle(2, 2'd0);
    ack1(2'd0);
    idle(2, 2'd2);

    // Level source on bit 0.
    reset1();
    wr(2'd1, 16'hFFFF, 2'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0001, 1'b0, 2'd0, 16'h0, 2'd0, 1'b0);
    step(1'b0, 16'h0001, 1'b0, 2'd0, 16'h0, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0001, 1'b0, 2'd0, 16'h0, 2'd0, 1'b0);
    idle(1, 2'd0);
    wr(2'd0, 16'h0001, 2'd0);
    wr(2'd3, 16'h0, 2'd2);
    idle(3, 2'd0);

    // Reset with bit 0 in service and bit 15 pending.
    reset1();
    wr(2'd1, 16'h0001, 2'd1);
    step(1'b0, 16'h0001, 1'b0, 2'd0, 16'h0, 2'd0, 1'b0);
    idle(1, 2'd0);
    ack1(2'd0);
    step(1'b0, 16'h8000, 1'b0, 2'd0, 16'h0, 2'd2, 1'b0);
    idle(2, 2'd0);
    reset1();
    idle(1, 2'd0);
    idle(1, 2'd1);
    idle(1, 2'd2);
    idle(1, 2'd3);

    // Randomised traffic.
    last_ack = 0;
    for (int n = 0; n < 3000; n++) begin
      logic r, w, a;
      src = 16'($urandom & $urandom & $urandom);
      r = ($urandom_range(0, 249) == 0);
      w = ($urandom_range(0, 3) == 0);
      a = !last_ack && ((m_pres >= 0) ? ($urandom_range(0, 2) == 0)
                                      : ($urandom_range(0, 15) == 0));
      step(r, src, w, 2'($urandom_range(0, 3)), 16'($urandom),
           2'($urandom_range(0, 3)), a);
      last_ack = a;
    end
    idle(2, 2'd0);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
